// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction fetch unit and its testbench.
package fetch_pkg;

  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [AW_DEF-1:0] pc;
    logic [DW_DEF-1:0] instr;
  } fetch_t;

  // Counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a single-cycle clear.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE     = (PW+1)'(1);

  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]  count;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  // Head reads as zero when empty so outputs are clean out of reset.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[PW-1:0]] = wdata;
        wr_ptr_d                = wr_ptr_q + ONE;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: takes PCs, issues memory reads, buffers returned words and
// hands {instr, pc} to decode in order; a flush discards buffered and in-flight fetches.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          pc_valid,
  input  logic [AW-1:0] pc,
  output logic          pc_ready,
  output logic          mem_req_valid,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_req_ready,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready
);

  localparam int            CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          req_valid_q, req_valid_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  logic pc_hs, req_hs, pop;
  logic rsp_keep, rsp_drop, rsp_any;
  logic pc_push, data_push;
  logic pc_full, pc_empty, data_full, data_empty;

  assign pc_hs  = pc_valid && pc_ready;
  assign req_hs = req_valid_q && mem_req_ready;
  assign pop    = instr_valid && instr_ready && !flush;

  // Stale responses always precede live ones, so while drop_q is non-zero every response is stale.
  assign rsp_drop = mem_rsp_valid && (drop_q != '0);
  assign rsp_keep = mem_rsp_valid && (drop_q == '0) && (inflight_q != '0);
  assign rsp_any  = rsp_drop || rsp_keep;

  assign pc_push   = req_hs && !flush;
  assign data_push = rsp_keep && !flush;

  assign pc_ready      = !flush && (occ_q < DEPTH_C) && (!req_valid_q || mem_req_ready);
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign instr_valid   = !data_empty;

  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    occ_d       = occ_q;
    inflight_d  = inflight_q;
    drop_d      = drop_q;

    if (flush) begin
      req_valid_d = 1'b0;
    end else if (pc_hs) begin
      req_valid_d = 1'b1;
      req_addr_d  = pc;
    end else if (req_hs) begin
      req_valid_d = 1'b0;
    end

    // drop_q stays within DEPTH as long as memory never holds more than DEPTH reads.
    if (flush) begin
      occ_d      = '0;
      inflight_d = '0;
      drop_d     = drop_q + inflight_q + CW'(req_hs) - CW'(rsp_any);
    end else begin
      occ_d      = occ_q + CW'(pc_hs) - CW'(pop);
      inflight_d = inflight_q + CW'(req_hs) - CW'(rsp_keep);
      drop_d     = drop_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      occ_q       <= '0;
      inflight_q  <= '0;
      drop_q      <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
    end
  end

  sync_fifo #(.W(AW), .DEPTH(DEPTH)) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (pc_push),
    .wdata (req_addr_q),
    .pop   (pop),
    .rdata (instr_pc),
    .full  (pc_full),
    .empty (pc_empty)
  );

  sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (data_push),
    .wdata (mem_rsp_data),
    .pop   (pop),
    .rdata (instr),
    .full  (data_full),
    .empty (data_empty)
  );

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> (inflight_q != '0 || drop_q != '0));
  a_pc_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(pc_push && pc_full));
  a_data_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(data_push && data_full));
  a_data_has_pc: assert property (@(posedge clk) disable iff (rst)
    instr_valid |-> !pc_empty);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model, queue-based reference model,
// a table-driven stream test, directed corner-case sequences and a randomized run.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, flush, pc_valid, pc_ready;
  logic [AW-1:0] pc, mem_req_addr, instr_pc;
  logic          mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data, instr;
  logic          instr_valid, instr_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .pc_valid      (pc_valid),
    .pc            (pc),
    .pc_ready      (pc_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            tag;
    int            due;
  } mem_ent_t;

  typedef struct {
    logic          pc_valid;
    logic [AW-1:0] pc;
    logic          instr_ready;
    logic          exp_pc_ready;
    logic          exp_instr_valid;
    logic [AW-1:0] exp_pc;
    logic [DW-1:0] exp_instr;
  } vec_t;

  // Memory model and reference model state
  mem_ent_t      mem_q[$];
  logic [AW-1:0] acc_q[$];
  fetch_t        exp_q[$];
  logic [DW-1:0] script_q[$];
  int            epoch = 0;
  int            cyc = 0;
  bit            mem_hold = 1'b0;
  bit            rnd_mem = 1'b0;

  int checks = 0;
  int errors = 0;

  logic          smp_pc_ready, smp_mem_req_valid, smp_instr_valid;
  logic          smp_pc_hs, smp_req_hs, smp_out_hs, smp_rsp;
  logic [AW-1:0] smp_mem_req_addr, smp_instr_pc;
  logic [DW-1:0] smp_instr;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a << 5) + 32'h13;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are sampled and checked
  // against the reference model, then the model advances on the observed handshakes.
  task automatic applyStimulus();
    int       live;
    int       occ;
    mem_ent_t ent;
    fetch_t   fe;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom;
    if (!rst && !mem_hold && mem_q.size() != 0 && mem_q[0].due <= cyc &&
        (!rnd_mem || $urandom_range(0, 2) != 0)) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_q[0].data;
    end
    #1;
    smp_pc_ready      = pc_ready;
    smp_mem_req_valid = mem_req_valid;
    smp_mem_req_addr  = mem_req_addr;
    smp_instr_valid   = instr_valid;
    smp_instr         = instr;
    smp_instr_pc      = instr_pc;
    smp_pc_hs         = pc_valid && pc_ready;
    smp_req_hs        = mem_req_valid && mem_req_ready;
    smp_out_hs        = instr_valid && instr_ready && !flush;
    smp_rsp           = mem_rsp_valid;
    if (!rst) begin
      live = 0;
      foreach (mem_q[i]) if (mem_q[i].tag == epoch) live++;
      occ = acc_q.size() + live + exp_q.size();
      checkOutput("pc_ready", 64'(pc_ready),
                  64'(!flush && occ < DEPTH && (acc_q.size() == 0 || mem_req_ready)));
      checkOutput("mem_req_valid", 64'(mem_req_valid), 64'(acc_q.size() != 0));
      if (acc_q.size() != 0 && mem_req_valid)
        checkOutput("mem_req_addr", 64'(mem_req_addr), 64'(acc_q[0]));
      checkOutput("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0 && instr_valid) begin
        checkOutput("instr_pc", 64'(instr_pc), 64'(exp_q[0].pc));
        checkOutput("instr", 64'(instr), 64'(exp_q[0].instr));
      end

      if (smp_out_hs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (mem_rsp_valid) begin
        ent = mem_q.pop_front();
        if (!flush && ent.tag == epoch) begin
          fe.pc    = ent.addr;
          fe.instr = ent.data;
          exp_q.push_back(fe);
        end
      end
      if (smp_req_hs) begin
        if (acc_q.size() != 0) void'(acc_q.pop_front());
        ent.addr = mem_req_addr;
        if (script_q.size() != 0) ent.data = script_q.pop_front();
        else if (rnd_mem)         ent.data = $urandom;
        else                      ent.data = mem_word(mem_req_addr);
        ent.tag = epoch;
        ent.due = cyc + 1 + (rnd_mem ? int'($urandom_range(0, 3)) : 0);
        mem_q.push_back(ent);
      end
      if (smp_pc_hs) acc_q.push_back(pc);
      if (flush) begin
        epoch++;
        acc_q.delete();
        exp_q.delete();
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    flush         = 1'b0;
    pc_valid      = 1'b0;
    pc            = '0;
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    mem_hold      = 1'b0;
  endtask

  // Reset held two cycles with random inputs; memory is reset along with the DUT.
  task automatic doReset();
    rst = 1'b1;
    repeat (2) begin
      flush         = 1'($urandom_range(0, 1));
      pc_valid      = 1'($urandom_range(0, 1));
      pc            = $urandom;
      mem_req_ready = 1'($urandom_range(0, 1));
      instr_ready   = 1'($urandom_range(0, 1));
      applyStimulus();
    end
    rst = 1'b0;
    setIdle();
    mem_q.delete();
    acc_q.delete();
    exp_q.delete();
    script_q.delete();
  endtask

  initial begin
    vec_t          tbl[8];
    int            accepted;
    int            delivered;
    logic [AW-1:0] nxt;
    logic [AW-1:0] last_pc;
    logic [DW-1:0] last_instr;

    tbl[0] = '{1'b1, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[1] = '{1'b1, 32'h4,  1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[2] = '{1'b1, 32'h8,  1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[3] = '{1'b1, 32'hC,  1'b1, 1'b1, 1'b1, 32'h0,  32'h13};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h4,  32'h93};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h8,  32'h113};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hC,  32'h193};
    tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  32'h0};

    setIdle();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;

    // Reset state
    doReset();
    applyStimulus();
    checkOutput("rst_instr_valid", 64'(smp_instr_valid), 64'(0));
    checkOutput("rst_mem_req_valid", 64'(smp_mem_req_valid), 64'(0));
    checkOutput("rst_pc_ready", 64'(smp_pc_ready), 64'(1));
    checkOutput("rst_mem_req_addr", 64'(smp_mem_req_addr), 64'(0));
    checkOutput("rst_instr", 64'(smp_instr), 64'(0));
    checkOutput("rst_instr_pc", 64'(smp_instr_pc), 64'(0));

    // Back-to-back stream with 1-cycle memory
    doReset();
    for (int i = 0; i < 8; i++) begin
      pc_valid    = tbl[i].pc_valid;
      pc          = tbl[i].pc;
      instr_ready = tbl[i].instr_ready;
      applyStimulus();
      checkOutput($sformatf("stream%0d_pc_ready", i), 64'(smp_pc_ready), 64'(tbl[i].exp_pc_ready));
      checkOutput($sformatf("stream%0d_instr_valid", i), 64'(smp_instr_valid), 64'(tbl[i].exp_instr_valid));
      if (tbl[i].exp_instr_valid) begin
        checkOutput($sformatf("stream%0d_instr_pc", i), 64'(smp_instr_pc), 64'(tbl[i].exp_pc));
        checkOutput($sformatf("stream%0d_instr", i), 64'(smp_instr), 64'(tbl[i].exp_instr));
      end
    end

    // Decode backpressure fills the unit to DEPTH
    doReset();
    instr_ready = 1'b0;
    pc_valid    = 1'b1;
    nxt         = 32'h200;
    accepted    = 0;
    for (int i = 0; i < 10; i++) begin
      pc = nxt;
      applyStimulus();
      if (smp_pc_hs) begin
        accepted++;
        nxt += 4;
      end
    end
    checkOutput("bp_accepted", 64'(accepted), 64'(DEPTH));
    checkOutput("bp_pc_ready_full", 64'(smp_pc_ready), 64'(0));
    pc_valid    = 1'b0;
    instr_ready = 1'b1;
    delivered   = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      if (smp_out_hs) begin
        checkOutput("bp_order_pc", 64'(smp_instr_pc), 64'(32'h200 + 4 * delivered));
        checkOutput("bp_order_instr", 64'(smp_instr), 64'(mem_word(32'h200 + 4 * delivered)));
        delivered++;
      end
    end
    checkOutput("bp_delivered", 64'(delivered), 64'(DEPTH));
    applyStimulus();
    checkOutput("bp_pc_ready_after", 64'(smp_pc_ready), 64'(1));

    // Memory stall holds the request address
    doReset();
    mem_req_ready = 1'b0;
    pc_valid      = 1'b1;
    pc            = 32'h40;
    applyStimulus();
    checkOutput("stall_accept", 64'(smp_pc_hs), 64'(1));
    pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("stall_req_valid", 64'(smp_mem_req_valid), 64'(1));
      checkOutput("stall_req_addr", 64'(smp_mem_req_addr), 64'(32'h40));
      checkOutput("stall_pc_ready", 64'(smp_pc_ready), 64'(0));
    end
    mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("stall_release_hs", 64'(smp_req_hs), 64'(1));
    checkOutput("stall_release_pc_ready", 64'(smp_pc_ready), 64'(1));
    pc_valid  = 1'b0;
    delivered = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      if (smp_out_hs) delivered++;
    end
    checkOutput("stall_delivered", 64'(delivered), 64'(2));

    // Flush with two reads in flight and one word buffered
    doReset();
    script_q    = '{32'h1111_0300, 32'hDEAD_0000, 32'hDEAD_0004, 32'h0010_0093};
    instr_ready = 1'b0;
    pc_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h300 + 32'(4 * i);
      applyStimulus();
    end
    pc_valid = 1'b0;
    mem_hold = 1'b1;
    applyStimulus();
    flush = 1'b1;
    applyStimulus();
    checkOutput("fif_pc_ready_in_flush", 64'(smp_pc_ready), 64'(0));
    flush       = 1'b0;
    mem_hold    = 1'b0;
    instr_ready = 1'b1;
    pc_valid    = 1'b1;
    pc          = 32'h100;
    delivered   = 0;
    last_pc     = '0;
    last_instr  = '0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus();
      pc_valid = 1'b0;
      if (smp_out_hs) begin
        delivered++;
        last_pc    = smp_instr_pc;
        last_instr = smp_instr;
      end
    end
    checkOutput("fif_delivered", 64'(delivered), 64'(1));
    checkOutput("fif_pc", 64'(last_pc), 64'(32'h100));
    checkOutput("fif_instr", 64'(last_instr), 64'(32'h0010_0093));

    // Flush coinciding with a response and a request handshake
    doReset();
    script_q = '{32'hAAAA_0001, 32'hCCCC_0001, 32'hDDDD_0001};
    pc_valid = 1'b1;
    pc       = 32'h500;
    applyStimulus();
    pc = 32'h504;
    applyStimulus();
    pc_valid = 1'b0;
    flush    = 1'b1;
    applyStimulus();
    checkOutput("coinc_rsp", 64'(smp_rsp), 64'(1));
    checkOutput("coinc_req_hs", 64'(smp_req_hs), 64'(1));
    flush      = 1'b0;
    pc_valid   = 1'b1;
    pc         = 32'h600;
    delivered  = 0;
    last_pc    = '0;
    last_instr = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      pc_valid = 1'b0;
      if (smp_out_hs) begin
        delivered++;
        last_pc    = smp_instr_pc;
        last_instr = smp_instr;
      end
    end
    checkOutput("coinc_delivered", 64'(delivered), 64'(1));
    checkOutput("coinc_pc", 64'(last_pc), 64'(32'h600));
    checkOutput("coinc_instr", 64'(last_instr), 64'(32'hDDDD_0001));

    // Randomized traffic with variable memory latency, flushes and a mid-run reset
    doReset();
    rnd_mem   = 1'b1;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset();
      flush         = ($urandom_range(0, 19) == 0);
      pc_valid      = ($urandom_range(0, 9) < 7);
      pc            = AW'($urandom_range(0, 255) * 4);
      instr_ready   = ($urandom_range(0, 3) != 0);
      mem_req_ready = ($urandom_range(0, 3) != 0) && (mem_q.size() < DEPTH);
      applyStimulus();
      if (smp_out_hs) delivered++;
    end
    setIdle();
    for (int i = 0; i < 30; i++) applyStimulus();
    checkOutput("rand_drain_instr_valid", 64'(smp_instr_valid), 64'(0));
    checkOutput("rand_drain_req_valid", 64'(smp_mem_req_valid), 64'(0));
    checkOutput("rand_some_delivered", 64'(delivered > 100), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
